// File: rtl/grid_game_engine.sv
// ============================================================================
// grid_game_engine
// Two-player X/O game on an N x N board: a cursor moves with wrap-around,
// marks are placed with BtnC, and each placement is checked for a line of K
// marks. Wins are counted per player with saturating scores.
//
// Ports
//   Clk, Reset             clock, asynchronous active-high reset
//   Start, Ack             begin a match (INI) / leave a finished round (DONE)
//   BtnL/BtnR/BtnU/BtnD    cursor moves, single-cycle pulses
//   BtnC                   place current player's mark at the cursor
//   Qi,Qs,Qx,Qo,Qk,Qd      one-hot state flags INI,STA,XTU,OTU,CHK,DONE
//   Pos                    cursor cell index r*N + c
//   Board                  2 bits per cell: 00 empty, 01 X, 10 O
//   Xwins, Owins, Draw     round result flags
//   Illegal                one-cycle pulse on a rejected placement
//   P1s, P2s               X and O win counts
// ============================================================================
module grid_game_engine #(
    parameter int unsigned N       = 3,
    parameter int unsigned K       = 3,
    parameter int unsigned SCORE_W = 12,
    localparam int unsigned C      = N * N,
    localparam int unsigned PW     = $clog2(C)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               BtnL,
    input  logic               BtnR,
    input  logic               BtnU,
    input  logic               BtnD,
    input  logic               BtnC,
    output logic               Qi,
    output logic               Qs,
    output logic               Qx,
    output logic               Qo,
    output logic               Qk,
    output logic               Qd,
    output logic [PW-1:0]      Pos,
    output logic [2*C-1:0]     Board,
    output logic               Xwins,
    output logic               Owins,
    output logic               Draw,
    output logic               Illegal,
    output logic [SCORE_W-1:0] P1s,
    output logic [SCORE_W-1:0] P2s
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned MW = $clog2(C + 1);

    // One-hot encoding so the state flags come straight from the register
    typedef enum logic [5:0] {
        S_INI  = 6'b000001,
        S_STA  = 6'b000010,
        S_XTU  = 6'b000100,
        S_OTU  = 6'b001000,
        S_CHK  = 6'b010000,
        S_DONE = 6'b100000
    } state_t;

    state_t               state_q, state_d;
    logic [2*C-1:0]       board_q, board_d;
    logic [RW-1:0]        row_q, row_d;
    logic [RW-1:0]        col_q, col_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [MW-1:0]        moves_q, moves_d;
    logic [SCORE_W-1:0]   p1s_q, p1s_d;
    logic [SCORE_W-1:0]   p2s_q, p2s_d;
    logic                 xwins_q, xwins_d;
    logic                 owins_q, owins_d;
    logic                 draw_q, draw_d;
    logic                 illegal_q, illegal_d;
    logic                 starter_q, starter_d;   // 0: X starts, 1: O starts
    logic                 mover_q, mover_d;       // 0: X moved last, 1: O
    logic                 win_c;

    // Scan every K-long window in all four directions for the last mover
    always_comb begin
        logic [1:0] mark;
        logic       line_h, line_v, line_d, line_a;
        mark  = mover_q ? 2'b10 : 2'b01;
        win_c = 1'b0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                line_h = (c + K <= N);
                line_v = (r + K <= N);
                line_d = (r + K <= N) && (c + K <= N);
                line_a = (r + K <= N) && (c + 1 >= K);
                for (int unsigned k = 0; k < K; k++) begin
                    if (c + k < N)
                        line_h = line_h && (board_q[2*(r*N + c + k) +: 2] == mark);
                    if (r + k < N)
                        line_v = line_v && (board_q[2*((r + k)*N + c) +: 2] == mark);
                    if ((r + k < N) && (c + k < N))
                        line_d = line_d && (board_q[2*((r + k)*N + c + k) +: 2] == mark);
                    if ((r + k < N) && (c >= k))
                        line_a = line_a && (board_q[2*((r + k)*N + c - k) +: 2] == mark);
                end
                win_c = win_c | line_h | line_v | line_d | line_a;
            end
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        col_d     = col_q;
        moves_d   = moves_q;
        p1s_d     = p1s_q;
        p2s_d     = p2s_q;
        xwins_d   = xwins_q;
        owins_d   = owins_q;
        draw_d    = draw_q;
        illegal_d = 1'b0;
        starter_d = starter_q;
        mover_d   = mover_q;

        case (state_q)
            S_INI: begin
                board_d   = '0;
                row_d     = '0;
                col_d     = '0;
                moves_d   = '0;
                p1s_d     = '0;
                p2s_d     = '0;
                xwins_d   = 1'b0;
                owins_d   = 1'b0;
                draw_d    = 1'b0;
                starter_d = 1'b0;
                mover_d   = 1'b0;
                if (Start)
                    state_d = S_STA;
            end
            S_STA: begin
                board_d = '0;
                row_d   = '0;
                col_d   = '0;
                moves_d = '0;
                xwins_d = 1'b0;
                owins_d = 1'b0;
                draw_d  = 1'b0;
                state_d = starter_q ? S_OTU : S_XTU;
            end
            S_XTU, S_OTU: begin
                // Placement beats movement; move priority is U > D > L > R
                if (BtnC) begin
                    if (board_q[2*pos_q +: 2] == 2'b00) begin
                        board_d[2*pos_q +: 2] = (state_q == S_OTU) ? 2'b10 : 2'b01;
                        moves_d = moves_q + MW'(1);
                        mover_d = (state_q == S_OTU);
                        state_d = S_CHK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (BtnU) begin
                    row_d = (row_q == '0) ? RW'(N - 1) : row_q - RW'(1);
                end else if (BtnD) begin
                    row_d = (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
                end else if (BtnL) begin
                    col_d = (col_q == '0) ? RW'(N - 1) : col_q - RW'(1);
                end else if (BtnR) begin
                    col_d = (col_q == RW'(N - 1)) ? '0 : col_q + RW'(1);
                end
            end
            S_CHK: begin
                if (win_c) begin
                    state_d = S_DONE;
                    if (mover_q) begin
                        owins_d = 1'b1;
                        if (p2s_q != {SCORE_W{1'b1}})
                            p2s_d = p2s_q + SCORE_W'(1);
                    end else begin
                        xwins_d = 1'b1;
                        if (p1s_q != {SCORE_W{1'b1}})
                            p1s_d = p1s_q + SCORE_W'(1);
                    end
                end else if (moves_q == MW'(C)) begin
                    draw_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = mover_q ? S_XTU : S_OTU;
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_INI;
                end else if (BtnL) begin
                    state_d   = S_STA;
                    starter_d = ~starter_q;
                end
            end
            default: state_d = S_INI;
        endcase

        pos_d = PW'(row_d) * PW'(N) + PW'(col_d);
    end

    // Register bank
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_INI;
            board_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pos_q     <= '0;
            moves_q   <= '0;
            p1s_q     <= '0;
            p2s_q     <= '0;
            xwins_q   <= 1'b0;
            owins_q   <= 1'b0;
            draw_q    <= 1'b0;
            illegal_q <= 1'b0;
            starter_q <= 1'b0;
            mover_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pos_q     <= pos_d;
            moves_q   <= moves_d;
            p1s_q     <= p1s_d;
            p2s_q     <= p2s_d;
            xwins_q   <= xwins_d;
            owins_q   <= owins_d;
            draw_q    <= draw_d;
            illegal_q <= illegal_d;
            starter_q <= starter_d;
            mover_q   <= mover_d;
        end
    end

    assign Qi      = state_q[0];
    assign Qs      = state_q[1];
    assign Qx      = state_q[2];
    assign Qo      = state_q[3];
    assign Qk      = state_q[4];
    assign Qd      = state_q[5];
    assign Pos     = pos_q;
    assign Board   = board_q;
    assign Xwins   = xwins_q;
    assign Owins   = owins_q;
    assign Draw    = draw_q;
    assign Illegal = illegal_q;
    assign P1s     = p1s_q;
    assign P2s     = p2s_q;

endmodule

// File: tb/tb_grid_game_engine.sv
// ============================================================================
// tb_grid_game_engine
// Three engines share one stimulus stream: u0 (N=3,K=3,SCORE_W=12),
// u1 (SCORE_W=2, score saturation) and u2 (N=5,K=4, long diagonal).
// Expectations are queued as stimulus is driven and compared after each edge.
// ============================================================================
module tb_grid_game_engine;

    logic Clk = 1'b0;
    logic Reset;
    logic Start, Ack, BtnL, BtnR, BtnU, BtnD, BtnC;

    always #5 Clk = ~Clk;

    wire        Qi0, Qs0, Qx0, Qo0, Qk0, Qd0, Xw0, Ow0, Dr0, Il0;
    wire [3:0]  Pos0;
    wire [17:0] Board0;
    wire [11:0] P1s0, P2s0;
    wire        Qi1, Qs1, Qx1, Qo1, Qk1, Qd1, Xw1, Ow1, Dr1, Il1;
    wire [3:0]  Pos1;
    wire [17:0] Board1;
    wire [1:0]  P1s1, P2s1;
    wire        Qi2, Qs2, Qx2, Qo2, Qk2, Qd2, Xw2, Ow2, Dr2, Il2;
    wire [4:0]  Pos2;
    wire [49:0] Board2;
    wire [11:0] P1s2, P2s2;

    grid_game_engine #(.N(3), .K(3), .SCORE_W(12)) u0 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .Qi(Qi0), .Qs(Qs0), .Qx(Qx0), .Qo(Qo0), .Qk(Qk0), .Qd(Qd0),
        .Pos(Pos0), .Board(Board0), .Xwins(Xw0), .Owins(Ow0), .Draw(Dr0),
        .Illegal(Il0), .P1s(P1s0), .P2s(P2s0));

    grid_game_engine #(.N(3), .K(3), .SCORE_W(2)) u1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .Qi(Qi1), .Qs(Qs1), .Qx(Qx1), .Qo(Qo1), .Qk(Qk1), .Qd(Qd1),
        .Pos(Pos1), .Board(Board1), .Xwins(Xw1), .Owins(Ow1), .Draw(Dr1),
        .Illegal(Il1), .P1s(P1s1), .P2s(P2s1));

    grid_game_engine #(.N(5), .K(4), .SCORE_W(12)) u2 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .Qi(Qi2), .Qs(Qs2), .Qx(Qx2), .Qo(Qo2), .Qk(Qk2), .Qd(Qd2),
        .Pos(Pos2), .Board(Board2), .Xwins(Xw2), .Owins(Ow2), .Draw(Dr2),
        .Illegal(Il2), .P1s(P1s2), .P2s(P2s2));

    localparam logic [5:0] S_INI  = 6'b000001;
    localparam logic [5:0] S_STA  = 6'b000010;
    localparam logic [5:0] S_XTU  = 6'b000100;
    localparam logic [5:0] S_OTU  = 6'b001000;
    localparam logic [5:0] S_CHK  = 6'b010000;
    localparam logic [5:0] S_DONE = 6'b100000;

    // Button vector order: {Start, Ack, U, D, L, R, C}
    localparam logic [6:0] B_0     = 7'b0000000;
    localparam logic [6:0] B_C     = 7'b0000001;
    localparam logic [6:0] B_R     = 7'b0000010;
    localparam logic [6:0] B_L     = 7'b0000100;
    localparam logic [6:0] B_D     = 7'b0001000;
    localparam logic [6:0] B_U     = 7'b0010000;
    localparam logic [6:0] B_ACK   = 7'b0100000;
    localparam logic [6:0] B_START = 7'b1000000;

    localparam logic [1:0] MX = 2'b01;
    localparam logic [1:0] MO = 2'b10;

    typedef enum int {K_Q, K_POS, K_ILL, K_BOARD, K_XW, K_OW, K_DRAW,
                      K_P1, K_P2, K_P1B, K_Q2, K_POS2, K_BOARD2, K_XW2} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [63:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [6:0]  btn;
        logic [5:0]  q;
        int          pos;
        logic        ill;
        logic [17:0] board;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[23];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] mb;
    int          cr, cc;

    function automatic logic [63:0] act_of(input kind_t k);
        case (k)
            K_Q:      return 64'({Qd0, Qk0, Qo0, Qx0, Qs0, Qi0});
            K_POS:    return 64'(Pos0);
            K_ILL:    return 64'(Il0);
            K_BOARD:  return 64'(Board0);
            K_XW:     return 64'(Xw0);
            K_OW:     return 64'(Ow0);
            K_DRAW:   return 64'(Dr0);
            K_P1:     return 64'(P1s0);
            K_P2:     return 64'(P2s0);
            K_P1B:    return 64'(P1s1);
            K_Q2:     return 64'({Qd2, Qk2, Qo2, Qx2, Qs2, Qi2});
            K_POS2:   return 64'(Pos2);
            K_BOARD2: return 64'(Board2);
            K_XW2:    return 64'(Xw2);
            default:  return 64'hDEAD;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic want(input kind_t k, input logic [63:0] v, input string nm);
        exp_t e;
        e.name = nm;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s/%s", e.name, e.kind.name()), act_of(e.kind), e.val);
        end
        chk("state_onehot", 64'($onehot({Qd0, Qk0, Qo0, Qx0, Qs0, Qi0})), 64'd1);
    endtask

    task automatic cyc(input logic [6:0] b);
        {Start, Ack, BtnU, BtnD, BtnL, BtnR, BtnC} = b;
        @(posedge Clk);
        #1;
        {Start, Ack, BtnU, BtnD, BtnL, BtnR, BtnC} = 7'b0;
        compare_all();
    endtask

    // Walk the cursor down then right (wrapping) to cell t
    task automatic goto(input int n, input int t, input bit sel);
        int    tr;
        int    tc;
        kind_t pk;
        tr = t / n;
        tc = t % n;
        pk = sel ? K_POS2 : K_POS;
        while (cr != tr) begin
            cr = (cr + 1) % n;
            want(pk, 64'(cr * n + cc), "goto_down");
            cyc(B_D);
        end
        while (cc != tc) begin
            cc = (cc + 1) % n;
            want(pk, 64'(cr * n + cc), "goto_right");
            cyc(B_R);
        end
    endtask

    task automatic place(input int n, input int t, input logic [1:0] mark,
                         input logic [5:0] nextq, input bit sel);
        kind_t qk;
        kind_t bk;
        qk = sel ? K_Q2 : K_Q;
        bk = sel ? K_BOARD2 : K_BOARD;
        goto(n, t, sel);
        mb[2*t +: 2] = mark;
        want(qk, 64'(S_CHK), "place_chk");
        want(bk, mb, "place_board");
        cyc(B_C);
        want(qk, 64'(nextq), "place_next");
        cyc(B_0);
    endtask

    task automatic round_begin(input logic [6:0] b, input logic [5:0] first);
        want(K_Q, 64'(S_STA), "round_sta");
        cyc(b);
        mb = '0;
        cr = 0;
        cc = 0;
        want(K_Q, 64'(first), "round_first");
        want(K_BOARD, 64'd0, "round_board");
        want(K_POS, 64'd0, "round_pos");
        want(K_XW, 64'd0, "round_xw");
        want(K_OW, 64'd0, "round_ow");
        want(K_DRAW, 64'd0, "round_draw");
        cyc(B_0);
    endtask

    task automatic result(input bit xw, input bit ow, input bit dr,
                          input int p1, input int p1b, input int p2);
        want(K_Q, 64'(S_DONE), "res_done");
        want(K_XW, 64'(xw), "res_xw");
        want(K_OW, 64'(ow), "res_ow");
        want(K_DRAW, 64'(dr), "res_draw");
        want(K_P1, 64'(p1), "res_p1");
        want(K_P1B, 64'(p1b), "res_p1_sat");
        want(K_P2, 64'(p2), "res_p2");
        cyc(B_0);
    endtask

    task automatic round_x_xstart();
        place(3, 0, MX, S_OTU, 0);
        place(3, 3, MO, S_XTU, 0);
        place(3, 1, MX, S_OTU, 0);
        place(3, 4, MO, S_XTU, 0);
        place(3, 2, MX, S_DONE, 0);
    endtask

    task automatic round_x_ostart();
        place(3, 3, MO, S_XTU, 0);
        place(3, 0, MX, S_OTU, 0);
        place(3, 4, MO, S_XTU, 0);
        place(3, 1, MX, S_OTU, 0);
        place(3, 6, MO, S_XTU, 0);
        place(3, 2, MX, S_DONE, 0);
    endtask

    task automatic want_reset_state(input string nm);
        want(K_Q, 64'(S_INI), nm);
        want(K_BOARD, 64'd0, nm);
        want(K_POS, 64'd0, nm);
        want(K_P1, 64'd0, nm);
        want(K_P2, 64'd0, nm);
        want(K_XW, 64'd0, nm);
        want(K_OW, 64'd0, nm);
        want(K_DRAW, 64'd0, nm);
        want(K_ILL, 64'd0, nm);
    endtask

    initial begin
        // Cursor / placement table, run in an O-first round starting at Pos 0
        tbl[0]  = '{"start_ack_ignored", B_START | B_ACK, S_OTU, 0, 1'b0, 18'h0};
        tbl[1]  = '{"r_0_1",         B_R,       S_OTU, 1, 1'b0, 18'h0};
        tbl[2]  = '{"r_1_2",         B_R,       S_OTU, 2, 1'b0, 18'h0};
        tbl[3]  = '{"r_wrap_2_0",    B_R,       S_OTU, 0, 1'b0, 18'h0};
        tbl[4]  = '{"l_wrap_0_2",    B_L,       S_OTU, 2, 1'b0, 18'h0};
        tbl[5]  = '{"d_2_5",         B_D,       S_OTU, 5, 1'b0, 18'h0};
        tbl[6]  = '{"d_5_8",         B_D,       S_OTU, 8, 1'b0, 18'h0};
        tbl[7]  = '{"r_wrap_8_6",    B_R,       S_OTU, 6, 1'b0, 18'h0};
        tbl[8]  = '{"r_6_7",         B_R,       S_OTU, 7, 1'b0, 18'h0};
        tbl[9]  = '{"d_wrap_7_1",    B_D,       S_OTU, 1, 1'b0, 18'h0};
        tbl[10] = '{"u_wrap_1_7",    B_U,       S_OTU, 7, 1'b0, 18'h0};
        tbl[11] = '{"d_wrap_7_1b",   B_D,       S_OTU, 1, 1'b0, 18'h0};
        tbl[12] = '{"d_1_4",         B_D,       S_OTU, 4, 1'b0, 18'h0};
        tbl[13] = '{"u_over_r",      B_U | B_R, S_OTU, 1, 1'b0, 18'h0};
        tbl[14] = '{"d_over_l",      B_D | B_L, S_OTU, 4, 1'b0, 18'h0};
        tbl[15] = '{"l_over_r",      B_L | B_R, S_OTU, 3, 1'b0, 18'h0};
        tbl[16] = '{"c_over_r",      B_C | B_R, S_CHK, 3, 1'b0, 18'h00080};
        tbl[17] = '{"chk_to_x",      B_0,       S_XTU, 3, 1'b0, 18'h00080};
        tbl[18] = '{"illegal_pulse", B_C,       S_XTU, 3, 1'b1, 18'h00080};
        tbl[19] = '{"illegal_clear", B_0,       S_XTU, 3, 1'b0, 18'h00080};
        tbl[20] = '{"u_3_0",         B_U,       S_XTU, 0, 1'b0, 18'h00080};
        tbl[21] = '{"x_at_0",        B_C,       S_CHK, 0, 1'b0, 18'h00081};
        tbl[22] = '{"chk_to_o",      B_0,       S_OTU, 0, 1'b0, 18'h00081};

        Reset = 1'b1;
        {Start, Ack, BtnU, BtnD, BtnL, BtnR, BtnC} = 7'b0;
        repeat (2) @(posedge Clk);
        #1;
        want_reset_state("por");
        compare_all();
        Reset = 1'b0;

        // Round 1: X starts and wins row 0
        round_begin(B_START, S_XTU);
        round_x_xstart();
        result(1'b1, 1'b0, 1'b0, 1, 1, 0);

        // Round 2: O starts; table covers wrap, priority, illegal
        round_begin(B_L, S_OTU);
        for (int i = 0; i < 23; i++) begin
            want(K_Q, 64'(tbl[i].q), tbl[i].name);
            want(K_POS, 64'(tbl[i].pos), tbl[i].name);
            want(K_ILL, 64'(tbl[i].ill), tbl[i].name);
            want(K_BOARD, 64'(tbl[i].board), tbl[i].name);
            cyc(tbl[i].btn);
        end
        mb = 64'h81;
        cr = 0;
        cc = 0;
        place(3, 4, MO, S_XTU, 0);
        place(3, 1, MX, S_OTU, 0);
        place(3, 6, MO, S_XTU, 0);
        place(3, 2, MX, S_DONE, 0);
        result(1'b1, 1'b0, 1'b0, 2, 2, 0);

        // Rounds 3 and 4: X keeps winning; 2-bit score saturates at 3
        round_begin(B_L, S_XTU);
        round_x_xstart();
        result(1'b1, 1'b0, 1'b0, 3, 3, 0);
        round_begin(B_L, S_OTU);
        round_x_ostart();
        result(1'b1, 1'b0, 1'b0, 4, 3, 0);

        // Round 5: full board X,O,X,X,O,O,O,X,X without a line
        round_begin(B_L, S_XTU);
        place(3, 0, MX, S_OTU, 0);
        place(3, 1, MO, S_XTU, 0);
        place(3, 2, MX, S_OTU, 0);
        place(3, 4, MO, S_XTU, 0);
        place(3, 3, MX, S_OTU, 0);
        place(3, 5, MO, S_XTU, 0);
        place(3, 7, MX, S_OTU, 0);
        place(3, 6, MO, S_XTU, 0);
        place(3, 8, MX, S_DONE, 0);
        result(1'b0, 1'b0, 1'b1, 4, 3, 0);

        // Round 6: O starts after the draw and wins row 0
        round_begin(B_L, S_OTU);
        place(3, 0, MO, S_XTU, 0);
        place(3, 3, MX, S_OTU, 0);
        place(3, 1, MO, S_XTU, 0);
        place(3, 4, MX, S_OTU, 0);
        place(3, 2, MO, S_DONE, 0);
        result(1'b0, 1'b1, 1'b0, 4, 3, 1);

        // Round 7: reset asynchronously while in OTU with nonzero scores
        round_begin(B_L, S_XTU);
        place(3, 0, MX, S_OTU, 0);
        want(K_POS, 64'd1, "pre_reset_move");
        cyc(B_R);
        #2;
        Reset = 1'b1;
        #1;
        want_reset_state("async_reset");
        compare_all();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Ack beats BtnL in DONE; INI then clears scores
        round_begin(B_START, S_XTU);
        round_x_xstart();
        result(1'b1, 1'b0, 1'b0, 1, 1, 0);
        want(K_Q, 64'(S_INI), "ack_beats_l");
        cyc(B_ACK | B_L);
        want(K_Q, 64'(S_INI), "ini_hold");
        want(K_P1, 64'd0, "ini_p1");
        want(K_P2, 64'd0, "ini_p2");
        want(K_BOARD, 64'd0, "ini_board");
        want(K_XW, 64'd0, "ini_xw");
        cyc(B_0);

        // N=5, K=4 engine: X diagonal 0,6,12,18
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        want(K_Q2, 64'(S_STA), "n5_sta");
        cyc(B_START);
        mb = '0;
        cr = 0;
        cc = 0;
        want(K_Q2, 64'(S_XTU), "n5_xtu");
        cyc(B_0);
        place(5, 0, MX, S_OTU, 1);
        place(5, 1, MO, S_XTU, 1);
        place(5, 6, MX, S_OTU, 1);
        place(5, 2, MO, S_XTU, 1);
        place(5, 12, MX, S_OTU, 1);
        place(5, 3, MO, S_XTU, 1);
        place(5, 18, MX, S_DONE, 1);
        want(K_XW2, 64'd1, "n5_xwins");
        want(K_Q2, 64'(S_DONE), "n5_done_hold");
        cyc(B_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
